// File: rtl/mvau_stream_sequencer.sv
// Handshake sequencer for the streaming MVAU input buffer and PE array.
// Optional perf counters (stall_cnt, bp_cnt) when MVAU_SEQ_PERF_EN is defined.
module mvau_stream_sequencer #(
  parameter int SF       = 4,
  parameter int NF       = 2,
  parameter int SF_T     = 2,
  parameter int NF_T     = 1,
  parameter int PIPE_LAT = 3,
  parameter int TO       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_v,
  output logic            in_rdy,
  input  logic            wgt_v,
  output logic            wgt_rdy,
  input  logic            dp_out_v,
  input  logic [TO-1:0]   dp_out,
  output logic            ib_wen,
  output logic            ib_ren,
  output logic [SF_T-1:0] sf_cnt,
  output logic [NF_T-1:0] nf_cnt,
  output logic            sf_clr,
  output logic            dp_en,
  output logic            out_v,
  input  logic            out_rdy,
  output logic [TO-1:0]   out,
  output logic            busy,
  output logic            vec_done
`ifdef MVAU_SEQ_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     bp_cnt
`endif
);

  localparam int LW = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [LW-1:0] lat_cnt;
  logic          res_pend;
  logic          need_act;
  logic          last_beat;
  logic          last_row;
  logic          can_fire;
  logic          fire;
  logic          acc;

  always_comb begin
    need_act  = (nf_cnt == '0);
    last_beat = (sf_cnt == SF_T'(SF - 1));
    last_row  = (nf_cnt == NF_T'(NF - 1));
    // a row's last beat waits until the previous result has left
    can_fire  = (state_q != S_FLUSH) &&
                !(last_beat && ((lat_cnt != '0) || res_pend));
    fire      = can_fire && wgt_v && (in_v || !need_act);
    wgt_rdy   = can_fire && (in_v || !need_act);
    in_rdy    = can_fire && need_act && wgt_v;
    dp_en     = fire;
    ib_wen    = fire && need_act;
    ib_ren    = fire && !need_act;
    sf_clr    = fire && (sf_cnt == '0);
    out_v     = res_pend;
    acc       = res_pend && out_rdy;
    busy      = (state_q != S_IDLE);
  end

  always_comb begin
    state_d  = state_q;
    vec_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fire)
          state_d = (last_beat && last_row) ? S_FLUSH : S_RUN;
      end
      S_RUN: begin
        if (fire && last_beat && last_row)
          state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (acc) begin
          state_d  = S_IDLE;
          vec_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sf_cnt   <= '0;
      nf_cnt   <= '0;
      lat_cnt  <= '0;
      res_pend <= 1'b0;
      out      <= '0;
    end else begin
      state_q <= state_d;
      if (fire) begin
        if (last_beat) begin
          sf_cnt <= '0;
          nf_cnt <= last_row ? '0 : nf_cnt + 1'b1;
        end else begin
          sf_cnt <= sf_cnt + 1'b1;
        end
      end
      if (fire && last_beat)
        lat_cnt <= LW'(PIPE_LAT);
      else if (lat_cnt != '0)
        lat_cnt <= lat_cnt - 1'b1;
      if (dp_out_v) begin
        out      <= dp_out;
        res_pend <= 1'b1;
      end else if (acc) begin
        res_pend <= 1'b0;
      end
    end
  end

`ifdef MVAU_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      bp_cnt    <= '0;
    end else begin
      if (wgt_v && !wgt_rdy && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (out_v && !out_rdy && (bp_cnt != '1))
        bp_cnt <= bp_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mvau_stream_sequencer.sv
// Randomized bench for mvau_stream_sequencer against a transaction-level model.
// Define MVAU_SEQ_PERF_EN to also check stall_cnt and bp_cnt.
module tb_mvau_stream_sequencer;

  localparam int SF   = 4;
  localparam int NF   = 2;
  localparam int SF_T = 2;
  localparam int NF_T = 1;
  localparam int PL   = 3;
  localparam int TO   = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_v, wgt_v, dp_out_v, out_rdy;
  logic [TO-1:0]   dp_out;
  logic            in_rdy, wgt_rdy, ib_wen, ib_ren;
  logic [SF_T-1:0] sf_cnt;
  logic [NF_T-1:0] nf_cnt;
  logic            sf_clr, dp_en, out_v, busy, vec_done;
  logic [TO-1:0]   out;
`ifdef MVAU_SEQ_PERF_EN
  logic [31:0]     stall_cnt, bp_cnt;
`endif

  mvau_stream_sequencer #(
    .SF(SF), .NF(NF), .SF_T(SF_T), .NF_T(NF_T),
    .PIPE_LAT(PL), .TO(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_v(in_v), .in_rdy(in_rdy),
    .wgt_v(wgt_v), .wgt_rdy(wgt_rdy),
    .dp_out_v(dp_out_v), .dp_out(dp_out),
    .ib_wen(ib_wen), .ib_ren(ib_ren),
    .sf_cnt(sf_cnt), .nf_cnt(nf_cnt),
    .sf_clr(sf_clr), .dp_en(dp_en),
    .out_v(out_v), .out_rdy(out_rdy), .out(out),
    .busy(busy), .vec_done(vec_done)
`ifdef MVAU_SEQ_PERF_EN
    , .stall_cnt(stall_cnt), .bp_cnt(bp_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: beat index within the vector, result timer, held result
  int          beat;
  int          dly;
  bit          held;
  bit          flush;
  bit          active;
  logic [TO-1:0] held_val;
  longint      stall_m;
  longint      bp_m;
  int          n_done;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    beat = 0; dly = -1; held = 0; flush = 0; active = 0;
    held_val = '0; stall_m = 0; bp_m = 0;
  endtask

  task automatic cycle(input int pin, input int pw, input int pr);
    bit lb, na, cf, f, xw, xa;
    @(negedge clk);
    in_v     = ($urandom_range(99) < pin);
    wgt_v    = ($urandom_range(99) < pw);
    out_rdy  = ($urandom_range(99) < pr);
    dp_out_v = (dly == 0);
    dp_out   = $urandom;
    #1;
    lb = ((beat % SF) == SF - 1);
    na = ((beat / SF) == 0);
    cf = !flush && !(lb && (dly >= 0 || held));
    f  = cf && wgt_v && (in_v || !na);
    xw = cf && (in_v || !na);
    xa = cf && na && wgt_v;
    chk("in_rdy", in_rdy, xa);
    chk("wgt_rdy", wgt_rdy, xw);
    chk("dp_en", dp_en, f);
    chk("ib_wen", ib_wen, f && na);
    chk("ib_ren", ib_ren, f && !na);
    chk("sf_clr", sf_clr, f && ((beat % SF) == 0));
    chk("sf_cnt", sf_cnt, beat % SF);
    chk("nf_cnt", nf_cnt, beat / SF);
    chk("out_v", out_v, held);
    if (held) chk("out", out, held_val);
    chk("busy", busy, active);
    chk("vec_done", vec_done, flush && held && out_rdy);
`ifdef MVAU_SEQ_PERF_EN
    chk("stall_cnt", stall_cnt, stall_m);
    chk("bp_cnt", bp_cnt, bp_m);
`endif
    @(posedge clk);
    if (wgt_v && !xw) stall_m++;
    if (held && !out_rdy) bp_m++;
    if (held && out_rdy) begin
      if (flush) begin
        flush = 0; active = 0; n_done++;
      end
      held = 0;
    end
    if (dp_out_v) begin
      held = 1; held_val = dp_out;
    end
    if (dly >= 0) dly--;
    if (f) begin
      active = 1;
      if (lb) dly = PL - 1;
      if (beat == SF * NF - 1) begin
        beat = 0; flush = 1;
      end else begin
        beat++;
      end
    end
  endtask

  task automatic run(input int n, input int pin, input int pw, input int pr);
    for (int i = 0; i < n; i++) cycle(pin, pw, pr);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_sf"}, sf_cnt, 0);
    chk({tag, "_nf"}, nf_cnt, 0);
    chk({tag, "_outv"}, out_v, 0);
    chk({tag, "_out"}, out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wrdy"}, wgt_rdy, 0);
    chk({tag, "_irdy"}, in_rdy, 0);
    chk({tag, "_den"}, dp_en, 0);
`ifdef MVAU_SEQ_PERF_EN
    chk({tag, "_stall"}, stall_cnt, 0);
    chk({tag, "_bp"}, bp_cnt, 0);
`endif
  endtask

  task automatic mid_reset();
    @(negedge clk);
    in_v = 0; wgt_v = 0; out_rdy = 0; dp_out_v = 0;
    #2 rst_n = 0;
    #1 reset_check("mrst");
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; in_v = 0; wgt_v = 0; out_rdy = 0;
    dp_out_v = 0; dp_out = '0; n_done = 0;
    model_reset();
    #12 reset_check("rst");
    @(negedge clk);
    rst_n = 1;
    run(200, 100, 100, 100);
    run(20, 100, 100, 0);
    run(200, 100, 100, 100);
    run(300, 50, 100, 70);
    run(300, 60, 80, 40);
    mid_reset();
    run(300, 90, 70, 80);
    run(25, 100, 100, 0);
    run(100, 100, 100, 100);
    mid_reset();
    run(300, 70, 90, 60);
    chk("vectors_done", n_done > 20, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
